// File: rtl/rx_eth2buf_pkg.sv
// Shared definitions for the MAC rx -> rbuf writer: FSM states, the
// header field layout and the byte-enable popcount.
package rx_eth2buf_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RX   = 2'd1,
        S_HDR  = 2'd2,
        S_DROP = 2'd3
    } rx_state_t;

    // Header QW: frame byte length in the low 16 bits, rest zero
    localparam int LEN_LSB = 0;
    localparam int LEN_MSB = 15;

    // Number of valid bytes in a beat (byte enables are contiguous from bit 0)
    function automatic logic [3:0] popcnt8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++)
            c = c + {3'b000, v[i]};
        return c;
    endfunction

endpackage

// File: rtl/rx_eth2buf.sv
// rx_eth2buf: writes MAC rx frames into the receive buffer as
// length-prefixed records (header QW + data QWs) and publishes completed
// good frames through committed_prod. Bad or overflowing frames are
// discarded by rolling wr_ptr back to the record start.
// Optional feature: define RX_DROP_CNT_EN to keep a 32-bit wrapping count
// of discarded frames; otherwise dropped_frames is tied to 0.
import rx_eth2buf_pkg::*;

module rx_eth2buf #(
    parameter int BW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [63:0]   rx_data,
    input  logic [7:0]    rx_data_valid,
    input  logic          rx_good_frame,
    input  logic          rx_bad_frame,
    output logic [BW-1:0] wr_addr,
    output logic [63:0]   wr_data,
    output logic          wr_en,
    output logic [BW:0]   committed_prod,
    input  logic [BW:0]   committed_cons,
    output logic [31:0]   dropped_frames
);

    localparam logic [BW:0] DEPTH = {1'b1, {BW{1'b0}}};
    localparam logic [BW:0] ROOM  = DEPTH - (BW+1)'(2);

    rx_state_t      state, state_n;
    logic [BW:0]    wr_ptr, wr_ptr_n;
    logic [BW:0]    sof_addr, sof_addr_n;
    logic [15:0]    byte_len, byte_len_n;
    logic [BW-1:0]  wr_addr_n;
    logic [63:0]    wr_data_n;
    logic           wr_en_n;
    logic [BW:0]    prod_n;
    logic           drop_inc;

    logic           beat;
    logic [BW:0]    occ;
    logic           full;
    logic [BW:0]    ptr_p1, ptr_p2;
    logic [16:0]    len_sum;
    logic [63:0]    hdr;

    assign beat    = |rx_data_valid;
    assign occ     = wr_ptr - committed_cons;
    assign full    = (occ == DEPTH);
    assign ptr_p1  = wr_ptr + (BW+1)'(1);
    assign ptr_p2  = wr_ptr + (BW+1)'(2);
    assign len_sum = {1'b0, byte_len} + {13'd0, popcnt8(rx_data_valid)};

    // Header word built from the running length
    always_comb begin
        hdr = '0;
        hdr[LEN_MSB:LEN_LSB] = byte_len;
    end

    // Next-state, pointer bookkeeping and registered-write selection
    always_comb begin
        state_n    = state;
        wr_ptr_n   = wr_ptr;
        sof_addr_n = sof_addr;
        byte_len_n = byte_len;
        wr_en_n    = 1'b0;
        wr_addr_n  = wr_addr;
        wr_data_n  = wr_data;
        prod_n     = committed_prod;
        drop_inc   = 1'b0;
        case (state)
            S_IDLE: begin
                if (beat) begin
                    // Need room for the header plus this first data QW
                    if (occ <= ROOM) begin
                        sof_addr_n = wr_ptr;
                        wr_en_n    = 1'b1;
                        wr_addr_n  = ptr_p1[BW-1:0];
                        wr_data_n  = rx_data;
                        wr_ptr_n   = ptr_p2;
                        byte_len_n = {12'd0, popcnt8(rx_data_valid)};
                        state_n    = S_RX;
                    end else begin
                        state_n = S_DROP;
                    end
                end
            end
            S_RX: begin
                if (rx_bad_frame) begin
                    wr_ptr_n = sof_addr;
                    drop_inc = 1'b1;
                    state_n  = S_IDLE;
                end else if (rx_good_frame) begin
                    // Header lands in the same cycle the pointer is published
                    wr_en_n   = 1'b1;
                    wr_addr_n = sof_addr[BW-1:0];
                    wr_data_n = hdr;
                    prod_n    = wr_ptr;
                    state_n   = S_HDR;
                end else if (beat) begin
                    if (full) begin
                        wr_ptr_n = sof_addr;
                        state_n  = S_DROP;
                    end else begin
                        wr_en_n    = 1'b1;
                        wr_addr_n  = wr_ptr[BW-1:0];
                        wr_data_n  = rx_data;
                        wr_ptr_n   = ptr_p1;
                        byte_len_n = len_sum[16] ? 16'hFFFF : len_sum[15:0];
                    end
                end
            end
            S_HDR: begin
                // A beat here violates IFG; its frame is thrown away
                state_n = beat ? S_DROP : S_IDLE;
            end
            S_DROP: begin
                if (rx_good_frame || rx_bad_frame) begin
                    drop_inc = 1'b1;
                    state_n  = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State, pointers and rbuf write port registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            wr_ptr         <= '0;
            sof_addr       <= '0;
            byte_len       <= '0;
            wr_en          <= 1'b0;
            wr_addr        <= '0;
            wr_data        <= '0;
            committed_prod <= '0;
        end else begin
            state          <= state_n;
            wr_ptr         <= wr_ptr_n;
            sof_addr       <= sof_addr_n;
            byte_len       <= byte_len_n;
            wr_en          <= wr_en_n;
            wr_addr        <= wr_addr_n;
            wr_data        <= wr_data_n;
            committed_prod <= prod_n;
        end
    end

`ifdef RX_DROP_CNT_EN
    logic [31:0] drop_cnt;

    // Wrapping count of bad and overflow drops
    always_ff @(posedge clk) begin
        if (rst)
            drop_cnt <= '0;
        else if (drop_inc)
            drop_cnt <= drop_cnt + 32'd1;
    end

    assign dropped_frames = drop_cnt;
`else
    logic unused_drop_inc;
    assign unused_drop_inc = drop_inc;
    assign dropped_frames  = '0;
`endif

endmodule

// File: tb/tb_rx_eth2buf.sv
// Scoreboard bench for rx_eth2buf at BW=4 (16-QW buffer). Expected rbuf
// writes are queued as frames are issued; a monitor pops and compares on
// every wr_en. Pointer and drop-count values are hand-computed constants.
module tb_rx_eth2buf;

    localparam int BW = 4;

    logic          clk;
    logic          rst;
    logic [63:0]   rx_data;
    logic [7:0]    rx_data_valid;
    logic          rx_good_frame;
    logic          rx_bad_frame;
    logic [BW-1:0] wr_addr;
    logic [63:0]   wr_data;
    logic          wr_en;
    logic [BW:0]   committed_prod;
    logic [BW:0]   committed_cons;
    logic [31:0]   dropped_frames;

    typedef struct packed {
        logic [BW-1:0] addr;
        logic [63:0]   data;
    } wr_t;

    wr_t expq[$];
    int  n_cmp = 0;
    int  n_err = 0;
    logic [BW:0] prod_before, prod_at_pulse;

    rx_eth2buf #(.BW(BW)) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_data        (rx_data),
        .rx_data_valid  (rx_data_valid),
        .rx_good_frame  (rx_good_frame),
        .rx_bad_frame   (rx_bad_frame),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_en          (wr_en),
        .committed_prod (committed_prod),
        .committed_cons (committed_cons),
        .dropped_frames (dropped_frames)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] bdata(input int fid, input int k);
        return {8'(fid), 48'hC0FFEE000000, 8'(k)};
    endfunction

    function automatic logic [31:0] exp_drop(input int n);
`ifdef RX_DROP_CNT_EN
        return 32'(n);
`else
        return 32'(n - n);
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rbuf write must match the head of the expected queue
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wr_t e;
            n_cmp++;
            if (expq.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: addr %0d data %0h, none expected", wr_addr, wr_data);
            end else begin
                e = expq.pop_front();
                if (wr_addr !== e.addr || wr_data !== e.data) begin
                    n_err++;
                    $display("FAIL rbuf_write: addr %0d data %0h expected addr %0d data %0h",
                             wr_addr, wr_data, e.addr, e.data);
                end
            end
        end
    end

    // Issue one frame; queue the writes it should produce (nwr data QWs
    // starting after sof, plus a header when hdr_len >= 0)
    task automatic send_frame(input int fid, input int nb, input logic [7:0] lastv,
                              input bit good, input int sof, input int nwr, input int hdr_len);
        for (int k = 0; k < nwr; k++)
            expq.push_back('{addr: BW'((sof + 1 + k) % 16), data: bdata(fid, k)});
        if (hdr_len >= 0)
            expq.push_back('{addr: BW'(sof % 16), data: {48'h0, 16'(hdr_len)}});
        for (int k = 0; k < nb; k++) begin
            rx_data       = bdata(fid, k);
            rx_data_valid = (k == nb - 1) ? lastv : 8'hFF;
            @(posedge clk); #1;
        end
        rx_data       = '0;
        rx_data_valid = '0;
        rx_good_frame = good;
        rx_bad_frame  = ~good;
        prod_before   = committed_prod;
        @(posedge clk); #1;
        prod_at_pulse = committed_prod;
        rx_good_frame = 1'b0;
        rx_bad_frame  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        rx_data        = '0;
        rx_data_valid  = '0;
        rx_good_frame  = 1'b0;
        rx_bad_frame   = 1'b0;
        committed_cons = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en",   64'(wr_en), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", wr_data, 64'd0);
        chk("rst_prod",    64'(committed_prod), 64'd0);
        chk("rst_dropped", 64'(dropped_frames), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 32-byte good frame: header 0x20 at 0, data 1..4
        send_frame(1, 4, 8'hFF, 1'b1, 0, 4, 32);
        chk("f1_prod_before_pulse", 64'(prod_before), 64'd0);
        chk("f1_prod_after_pulse",  64'(prod_at_pulse), 64'd5);
        chk("f1_prod", 64'(committed_prod), 64'd5);

        // 21-byte frame, short last beat
        send_frame(2, 3, 8'h1F, 1'b1, 5, 3, 21);
        chk("f2_prod", 64'(committed_prod), 64'd9);

        // Bad frame: writes land, then rolled back, no commit
        send_frame(3, 3, 8'hFF, 1'b0, 9, 3, -1);
        chk("f3_prod",    64'(committed_prod), 64'd9);
        chk("f3_dropped", 64'(dropped_frames), 64'(exp_drop(1)));

        // Next frame reuses the rolled-back space
        send_frame(4, 2, 8'hFF, 1'b1, 9, 2, 16);
        chk("f4_prod", 64'(committed_prod), 64'd12);

        // Overflow: 4th beat arrives at occupancy 16 -> drop
        send_frame(5, 5, 8'hFF, 1'b1, 12, 3, -1);
        chk("f5_prod",    64'(committed_prod), 64'd12);
        chk("f5_dropped", 64'(dropped_frames), 64'(exp_drop(2)));

        // Consumer catches up; frame wraps the buffer end
        committed_cons = 5'd12;
        send_frame(6, 4, 8'hFF, 1'b1, 12, 4, 32);
        chk("f6_prod_wrap", 64'(committed_prod), 64'd17);

        // Occupancy 15 at frame start -> dropped without any write
        committed_cons = 5'd2;
        send_frame(7, 2, 8'hFF, 1'b1, 0, 0, -1);
        chk("f7_prod",    64'(committed_prod), 64'd17);
        chk("f7_dropped", 64'(dropped_frames), 64'(exp_drop(3)));

        // Occupancy 14 at frame start -> just fits
        committed_cons = 5'd3;
        send_frame(8, 1, 8'hFF, 1'b1, 17, 1, 8);
        chk("f8_prod", 64'(committed_prod), 64'd19);

        // Reset during the third beat of a frame
        committed_cons = 5'd19;
        expq.push_back('{addr: BW'(4), data: bdata(9, 0)});
        expq.push_back('{addr: BW'(5), data: bdata(9, 1)});
        for (int k = 0; k < 3; k++) begin
            rx_data       = bdata(9, k);
            rx_data_valid = 8'hFF;
            if (k == 2) rst = 1'b1;
            @(posedge clk); #1;
        end
        chk("mid_rst_wr_en",   64'(wr_en), 64'd0);
        chk("mid_rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("mid_rst_wr_data", wr_data, 64'd0);
        chk("mid_rst_prod",    64'(committed_prod), 64'd0);
        chk("mid_rst_dropped", 64'(dropped_frames), 64'd0);
        rst            = 1'b0;
        rx_data        = '0;
        rx_data_valid  = '0;
        committed_cons = '0;
        @(posedge clk); #1;

        // First frame after reset starts at address 0
        send_frame(10, 1, 8'h0F, 1'b1, 0, 1, 4);
        chk("post_rst_prod", 64'(committed_prod), 64'd2);

        chk("writes_outstanding", 64'(expq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
